jim_bus_bridge: RTL

Responder on the BBC 1MHz bus that gives the host paged read and write access to the external 512KB SRAM through the JIM window. The 6502 sees it as page FD, with paging and status registers in page FC. It runs entirely in the clk50 domain: the bus is oversampled, and every SRAM access goes through a req/ack port to the SRAM arbiter owned by the video/life engine. It completes the host read path, which the current design does not service.

---
 rtl/jim_pkg.sv | 32 +++
 rtl/bus_sync.sv | 61 ++++++
 rtl/jim_bus_bridge.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/jim_pkg.sv
// jim_pkg: shared definitions for the JIM bus bridge.
//   - FC-page register offsets (paging high/low, status)
//   - magic value that enables the JIM window
//   - status bit indices
//   - bus FSM state enum
package jim_pkg;

  localparam logic [7:0] REG_PAGE_HI = 8'hFF;  // page[18:16] + window enable
  localparam logic [7:0] REG_PAGE_LO = 8'hFE;  // page[15:8]
  localparam logic [7:0] REG_STATUS  = 8'hFD;  // sticky error flags, read-only

  // Upper five bits of a REG_PAGE_HI write must match this to open the window.
  localparam logic [4:0] JIM_MAGIC = 5'b11001;

  localparam int ST_TIMEOUT_BIT = 0;  // read missed its bus deadline
  localparam int ST_OVERRUN_BIT = 1;  // FD write dropped, previous one unacked

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_RD_REQ,
    S_HOLD,
    S_REG,
    S_WR_POST,
    S_WAIT_LOW
  } jim_state_e;

  function automatic logic is_fc_reg(input logic [7:0] addr);
    return (addr == REG_PAGE_HI) || (addr == REG_PAGE_LO) || (addr == REG_STATUS);
  endfunction

endpackage

// File: rtl/bus_sync.sv
// bus_sync: brings the asynchronous 1MHz bus control lines into clk50.
// Ports:
//   clk50, rst_n            clock, async active-low reset
//   clke, rnw, pgfc_n, pgfd_n  raw bus control inputs
//   clke_rise, clke_fall    one-cycle pulses on synchronized clke edges
//   rnw_s, pgfc_n_s, pgfd_n_s  synchronized copies of the other lines
// Select lines reset to their inactive (high) level so nothing decodes
// as a hit while the chains fill after reset.
module bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic clke,
  input  logic rnw,
  input  logic pgfc_n,
  input  logic pgfd_n,
  output logic clke_rise,
  output logic clke_fall,
  output logic rnw_s,
  output logic pgfc_n_s,
  output logic pgfd_n_s
);

  logic [SYNC_STAGES-1:0] clke_q;
  logic [SYNC_STAGES-1:0] rnw_q;
  logic [SYNC_STAGES-1:0] fc_q;
  logic [SYNC_STAGES-1:0] fd_q;
  logic                   clke_prev_q;
  logic                   clke_s;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      clke_q      <= '0;
      rnw_q       <= '1;
      fc_q        <= '1;
      fd_q        <= '1;
      clke_prev_q <= 1'b0;
    end else begin
      clke_q[0] <= clke;
      rnw_q[0]  <= rnw;
      fc_q[0]   <= pgfc_n;
      fd_q[0]   <= pgfd_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clke_q[i] <= clke_q[i-1];
        rnw_q[i]  <= rnw_q[i-1];
        fc_q[i]   <= fc_q[i-1];
        fd_q[i]   <= fd_q[i-1];
      end
      clke_prev_q <= clke_s;
    end
  end

  assign clke_s    = clke_q[SYNC_STAGES-1];
  assign clke_rise = clke_s & ~clke_prev_q;
  assign clke_fall = ~clke_s & clke_prev_q;
  assign rnw_s     = rnw_q[SYNC_STAGES-1];
  assign pgfc_n_s  = fc_q[SYNC_STAGES-1];
  assign pgfd_n_s  = fd_q[SYNC_STAGES-1];

endmodule

// File: rtl/jim_bus_bridge.sv
// jim_bus_bridge: 1MHz bus responder giving the host paged access to the
// 512KB SRAM through the JIM window (page FD), with paging/status
// registers in page FC. Runs entirely in clk50; the bus is oversampled.
// Ports:
//   clk50, rst_n                 clock, async active-low reset
//   clke, rnw, pgfc_n, pgfd_n    bus control (asynchronous)
//   bus_addr, bus_data_in        bus address low byte / host write data
//   bus_data_out, bus_data_oe    read data to host and its drive enable
//   mem_req/we/addr/wdata        SRAM request port to the arbiter
//   mem_ack, mem_rdata           arbiter completion pulse and read data
//   jim_selected                 JIM window enabled
//   dbg_state                    current bus FSM state
//
// SRAM handshake: mem_req rises with mem_we/mem_addr/mem_wdata stable and
// stays high, unchanged, until the single-cycle mem_ack. The ack cycle still
// counts as outstanding; a new request can only start the cycle after.
// Only one request is ever outstanding.
module jim_bus_bridge
  import jim_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLE_DLY  = 16,
  parameter int RD_DEADLINE = 20
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic        clke,
  input  logic        rnw,
  input  logic        pgfc_n,
  input  logic        pgfd_n,
  input  logic [7:0]  bus_addr,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        bus_data_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        jim_selected,
  output jim_state_e  dbg_state
);

  logic clke_rise, clke_fall, rnw_s, pgfc_n_s, pgfd_n_s;

  bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk50     (clk50),
    .rst_n     (rst_n),
    .clke      (clke),
    .rnw       (rnw),
    .pgfc_n    (pgfc_n),
    .pgfd_n    (pgfd_n),
    .clke_rise (clke_rise),
    .clke_fall (clke_fall),
    .rnw_s     (rnw_s),
    .pgfc_n_s  (pgfc_n_s),
    .pgfd_n_s  (pgfd_n_s)
  );

  jim_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;          // t: cycles since detected clke rise
  logic [7:0]  out_q, out_d;
  logic        oe_q, oe_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [18:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        jim_sel_q, jim_sel_d;
  logic [18:8] page_q, page_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  smp_addr_q, smp_addr_d;
  logic [7:0]  smp_data_q, smp_data_d;
  logic        smp_rnw_q, smp_rnw_d;
  logic        rd_issued_q, rd_issued_d;  // this bus cycle's read is on the port

  logic [7:0]  reg_rdata;
  logic        fc_hit, fd_hit, rd_done;

  always_comb begin
    reg_rdata = 8'h00;
    case (bus_addr)
      REG_PAGE_HI: reg_rdata = {jim_sel_q, 4'b0000, page_q[18:16]};
      REG_PAGE_LO: reg_rdata = page_q[15:8];
      REG_STATUS:  reg_rdata = {6'b000000, status_q};
      default:     reg_rdata = 8'h00;
    endcase
  end

  assign fc_hit = !pgfc_n_s && is_fc_reg(bus_addr);
  assign fd_hit = !pgfd_n_s && jim_sel_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    out_d       = out_q;
    oe_d        = oe_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    jim_sel_d   = jim_sel_q;
    page_d      = page_q;
    status_d    = status_q;
    smp_addr_d  = smp_addr_q;
    smp_data_d  = smp_data_q;
    smp_rnw_d   = smp_rnw_q;
    rd_issued_d = rd_issued_q;
    rd_done     = 1'b0;

    // Any outstanding request (posted write or abandoned read) retires on ack,
    // whatever the bus side is doing.
    if (mem_req_q && mem_ack) mem_req_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        oe_d  = 1'b0;
        cnt_d = 8'd0;
        if (clke_rise) begin
          state_d = S_SAMPLE;
          cnt_d   = 8'd1;
        end
      end

      S_SAMPLE: begin
        if (clke_fall) begin
          state_d = S_IDLE;  // runt cycle: nothing latched, nothing changed
        end else if (cnt_q == 8'(SAMPLE_DLY)) begin
          smp_addr_d = bus_addr;
          smp_data_d = bus_data_in;
          smp_rnw_d  = rnw_s;
          if (fc_hit) begin
            if (rnw_s) begin
              out_d = reg_rdata;
              oe_d  = 1'b1;
            end
            state_d = S_REG;
          end else if (fd_hit && rnw_s) begin
            state_d = S_RD_REQ;
            if (!mem_req_q) begin
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b0;
              mem_addr_d  = {page_q, bus_addr};
              rd_issued_d = 1'b1;
            end
          end else if (fd_hit) begin
            state_d = S_WR_POST;
            if (!mem_req_q) begin
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = {page_q, bus_addr};
              mem_wdata_d = bus_data_in;
            end else begin
              status_d[ST_OVERRUN_BIT] = 1'b1;
            end
          end else begin
            state_d = S_WAIT_LOW;
          end
        end
      end

      S_REG: begin
        if (!smp_rnw_q) begin
          case (smp_addr_q)
            REG_PAGE_HI: begin
              page_d[18:16] = smp_data_q[2:0];
              jim_sel_d     = (smp_data_q[7:3] == JIM_MAGIC);
            end
            REG_PAGE_LO: page_d[15:8] = smp_data_q;
            default: ;
          endcase
        end else if (smp_addr_q == REG_STATUS) begin
          status_d = 2'b00;  // value already captured for the bus
        end
        if (clke_fall) begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
        end else begin
          state_d = smp_rnw_q ? S_HOLD : S_WAIT_LOW;
        end
      end

      S_RD_REQ: begin
        if (clke_fall) begin
          state_d     = S_IDLE;
          rd_issued_d = 1'b0;
        end else begin
          if (!rd_issued_q) begin
            // Held behind a posted write; go as soon as the port is free.
            if (!mem_req_q) begin
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b0;
              mem_addr_d  = {page_q, smp_addr_q};
              rd_issued_d = 1'b1;
            end
          end else if (mem_ack) begin
            out_d       = mem_rdata;
            oe_d        = 1'b1;
            rd_done     = 1'b1;
            rd_issued_d = 1'b0;
            state_d     = S_HOLD;
          end
          // Deadline missed: present FF. The request stays up until its ack,
          // which then only retires it; the late data never reaches the bus.
          if (!rd_done && cnt_q >= 8'(RD_DEADLINE - 1)) begin
            out_d                    = 8'hFF;
            oe_d                     = 1'b1;
            status_d[ST_TIMEOUT_BIT] = 1'b1;
            rd_issued_d              = 1'b0;
            state_d                  = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (clke_fall) begin
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_WR_POST: begin
        state_d = clke_fall ? S_IDLE : S_WAIT_LOW;
      end

      S_WAIT_LOW: begin
        if (clke_fall) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      out_q       <= 8'h00;
      oe_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 19'd0;
      mem_wdata_q <= 8'h00;
      jim_sel_q   <= 1'b0;
      page_q      <= '0;
      status_q    <= 2'b00;
      smp_addr_q  <= 8'h00;
      smp_data_q  <= 8'h00;
      smp_rnw_q   <= 1'b1;
      rd_issued_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      oe_q        <= oe_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      jim_sel_q   <= jim_sel_d;
      page_q      <= page_d;
      status_q    <= status_d;
      smp_addr_q  <= smp_addr_d;
      smp_data_q  <= smp_data_d;
      smp_rnw_q   <= smp_rnw_d;
      rd_issued_q <= rd_issued_d;
    end
  end

  assign bus_data_out = out_q;
  assign bus_data_oe  = oe_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign jim_selected = jim_sel_q;
  assign dbg_state    = state_q;

endmodule
